selector_color: RTL and testbench

SELECTOR_COLOR -- requirements
Module: selector_color

---
 rtl/selector_color_pkg.sv | 16 +
 rtl/selector_color_if.sv | 34 +++
 rtl/selector_color_antirrebote.sv | 108 ++++++++++
 rtl/selector_color.sv | 64 ++++++
 tb/tb_selector_color.sv | 128 ++++++++++++
 5 files changed

// File: rtl/selector_color_pkg.sv
// Shared definitions for the colour selector: per-channel debounce FSM state
// encoding and the default filter length.
//   NFiltroDefault : stable cycles required to accept a level change (10 ms at 100 MHz)
//   estado_e       : debounce FSM states
package selector_color_pkg;

    localparam int unsigned NFiltroDefault = 1000000;

    typedef enum logic [1:0] {
        StBajo,
        StFiltroAlto,
        StAlto,
        StFiltroBajo
    } estado_e;

endpackage

// File: rtl/selector_color_if.sv
// Button/enable bundle between the pushbutton side and the colour selector.
//   Boton_R/G/B  : raw asynchronous pushbuttons, active-high
//   en_rgb       : registered channel enables {R,G,B}
//   pulso_rgb    : one-cycle strobe per channel on each accepted press
//   boton_limpio : debounced button levels {R,G,B}
// master drives the buttons; slave is the selector itself.
interface selector_color_if;

    logic       Boton_R;
    logic       Boton_G;
    logic       Boton_B;
    logic [2:0] en_rgb;
    logic [2:0] pulso_rgb;
    logic [2:0] boton_limpio;

    modport master (
        output Boton_R,
        output Boton_G,
        output Boton_B,
        input  en_rgb,
        input  pulso_rgb,
        input  boton_limpio
    );

    modport slave (
        input  Boton_R,
        input  Boton_G,
        input  Boton_B,
        output en_rgb,
        output pulso_rgb,
        output boton_limpio
    );

endinterface

// File: rtl/selector_color_antirrebote.sv
// Single-channel pushbutton debouncer: 2-flop synchronizer, stability counter
// and a 4-state FSM.
//   reloj    : system clock, rising edge
//   resetM   : synchronous active-high reset
//   i_boton  : raw asynchronous button level
//   o_limpio : registered debounced level
//   o_pulso  : registered one-cycle strobe on each accepted press
//   o_acepta : press being accepted on the coming edge (from registered state only)
module antirrebote
    import selector_color_pkg::*;
#(
    parameter int unsigned N_FILTRO = NFiltroDefault
) (
    input  logic reloj,
    input  logic resetM,
    input  logic i_boton,
    output logic o_limpio,
    output logic o_pulso,
    output logic o_acepta
);

    localparam int unsigned       AnchoCnt = $clog2(N_FILTRO);
    localparam logic [AnchoCnt-1:0] CntMax = AnchoCnt'(N_FILTRO - 1);
    localparam logic [AnchoCnt-1:0] CntUno = AnchoCnt'(1);

    logic [1:0]          r_sync;
    estado_e             r_estado;
    estado_e             w_estado_sig;
    logic [AnchoCnt-1:0] r_cnt;
    logic [AnchoCnt-1:0] w_cnt_sig;
    logic                r_limpio;
    logic                r_pulso;
    logic                w_sync;
    logic                w_acepta;

    assign w_sync = r_sync[1];

    always_ff @(posedge reloj) begin
        if (resetM) begin
            r_sync   <= 2'b00;
            r_estado <= StBajo;
            r_cnt    <= '0;
            r_limpio <= 1'b0;
            r_pulso  <= 1'b0;
        end else begin
            r_sync   <= {r_sync[0], i_boton};
            r_estado <= w_estado_sig;
            r_cnt    <= w_cnt_sig;
            // Decoded from next state so the level leaves a flop aligned with r_estado.
            r_limpio <= (w_estado_sig == StAlto) || (w_estado_sig == StFiltroBajo);
            r_pulso  <= w_acepta;
        end
    end

    // Counter only ever counts up to CntMax, so it cannot wrap.
    always_comb begin
        w_estado_sig = r_estado;
        w_cnt_sig    = r_cnt;
        w_acepta     = 1'b0;
        case (r_estado)
            StBajo: begin
                if (w_sync) begin
                    w_estado_sig = StFiltroAlto;
                    w_cnt_sig    = CntUno;
                end
            end
            StFiltroAlto: begin
                if (!w_sync) begin
                    w_estado_sig = StBajo;
                    w_cnt_sig    = '0;
                end else if (r_cnt == CntMax) begin
                    w_estado_sig = StAlto;
                    w_cnt_sig    = '0;
                    w_acepta     = 1'b1;
                end else begin
                    w_cnt_sig = r_cnt + 1'b1;
                end
            end
            StAlto: begin
                if (!w_sync) begin
                    w_estado_sig = StFiltroBajo;
                    w_cnt_sig    = CntUno;
                end
            end
            StFiltroBajo: begin
                if (w_sync) begin
                    w_estado_sig = StAlto;
                    w_cnt_sig    = '0;
                end else if (r_cnt == CntMax) begin
                    // Release: no toggle, no strobe.
                    w_estado_sig = StBajo;
                    w_cnt_sig    = '0;
                end else begin
                    w_cnt_sig = r_cnt + 1'b1;
                end
            end
            default: begin
                w_estado_sig = StBajo;
                w_cnt_sig    = '0;
            end
        endcase
    end

    assign o_limpio = r_limpio;
    assign o_pulso  = r_pulso;
    assign o_acepta = w_acepta;

endmodule

// File: rtl/selector_color.sv
// Colour selector: three debounced pushbuttons toggle the {R,G,B} enables.
//   reloj    : system clock, rising edge
//   resetM   : synchronous active-high reset
//   bus      : slave side of selector_color_if (buttons in; en_rgb, pulso_rgb,
//              boton_limpio out)
// Parameters: N_FILTRO stable cycles to accept a level change; EN_RESET en_rgb reset value.
module selector_color
    import selector_color_pkg::*;
#(
    parameter int unsigned N_FILTRO = NFiltroDefault,
    parameter logic [2:0]  EN_RESET = 3'b000
) (
    input  logic              reloj,
    input  logic              resetM,
    selector_color_if.slave   bus
);

    logic [2:0] w_limpio;
    logic [2:0] w_pulso;
    logic [2:0] w_acepta;
    logic [2:0] r_en_rgb;

    antirrebote #(.N_FILTRO(N_FILTRO)) u_rojo (
        .reloj    (reloj),
        .resetM   (resetM),
        .i_boton  (bus.Boton_R),
        .o_limpio (w_limpio[2]),
        .o_pulso  (w_pulso[2]),
        .o_acepta (w_acepta[2])
    );

    antirrebote #(.N_FILTRO(N_FILTRO)) u_verde (
        .reloj    (reloj),
        .resetM   (resetM),
        .i_boton  (bus.Boton_G),
        .o_limpio (w_limpio[1]),
        .o_pulso  (w_pulso[1]),
        .o_acepta (w_acepta[1])
    );

    antirrebote #(.N_FILTRO(N_FILTRO)) u_azul (
        .reloj    (reloj),
        .resetM   (resetM),
        .i_boton  (bus.Boton_B),
        .o_limpio (w_limpio[0]),
        .o_pulso  (w_pulso[0]),
        .o_acepta (w_acepta[0])
    );

    // Toggle on the same edge the strobe register is set, so en_rgb and
    // pulso_rgb change together; all channels are independent.
    always_ff @(posedge reloj) begin
        if (resetM) begin
            r_en_rgb <= EN_RESET;
        end else begin
            r_en_rgb <= r_en_rgb ^ w_acepta;
        end
    end

    assign bus.en_rgb       = r_en_rgb;
    assign bus.pulso_rgb    = w_pulso;
    assign bus.boton_limpio = w_limpio;

endmodule

// File: tb/tb_selector_color.sv
// Directed self-checking bench for selector_color with N_FILTRO=4, EN_RESET=000.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_selector_color;

    logic reloj;
    logic resetM;
    int   checks;
    int   errors;

    selector_color_if sel ();

    selector_color #(
        .N_FILTRO (4),
        .EN_RESET (3'b000)
    ) dut (
        .reloj  (reloj),
        .resetM (resetM),
        .bus    (sel)
    );

    initial reloj = 1'b0;
    always #5 reloj = ~reloj;

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge reloj);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] en, input logic [2:0] pu,
                           input logic [2:0] li);
        chk({tag, ".en"}, sel.en_rgb, en);
        chk({tag, ".pulso"}, sel.pulso_rgb, pu);
        chk({tag, ".limpio"}, sel.boton_limpio, li);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        resetM      = 1'b1;
        sel.Boton_R = 1'b0;
        sel.Boton_G = 1'b0;
        sel.Boton_B = 1'b0;

        // Reset values after the first edge.
        ticks(1);
        chk_all("reset", 3'b000, 3'b000, 3'b000);
        resetM = 1'b0;

        // Red press: sampled from the next edge k, toggle visible after k+5.
        sel.Boton_R = 1'b1;
        ticks(5);
        chk_all("r_before", 3'b000, 3'b000, 3'b000);
        ticks(1);
        chk_all("r_accept", 3'b100, 3'b100, 3'b100);
        ticks(1);
        chk_all("r_pulse_end", 3'b100, 3'b000, 3'b100);
        ticks(15);
        chk_all("r_held", 3'b100, 3'b000, 3'b100);

        // Red release: clean level drops on the 6th edge, enables untouched.
        sel.Boton_R = 1'b0;
        ticks(5);
        chk_all("r_rel_before", 3'b100, 3'b000, 3'b100);
        ticks(1);
        chk_all("r_rel_after", 3'b100, 3'b000, 3'b000);

        // Green glitches: 3 high, 1 low, five times; nothing may change.
        for (int rep = 0; rep < 5; rep++) begin
            sel.Boton_G = 1'b1;
            for (int j = 0; j < 3; j++) begin
                ticks(1);
                chk_all("g_glitch_hi", 3'b100, 3'b000, 3'b000);
            end
            sel.Boton_G = 1'b0;
            ticks(1);
            chk_all("g_glitch_lo", 3'b100, 3'b000, 3'b000);
        end
        ticks(6);
        chk_all("g_glitch_end", 3'b100, 3'b000, 3'b000);

        // Red and blue together from en=100.
        sel.Boton_R = 1'b1;
        sel.Boton_B = 1'b1;
        ticks(5);
        chk_all("rb_before", 3'b100, 3'b000, 3'b000);
        ticks(1);
        chk_all("rb_accept", 3'b001, 3'b101, 3'b101);
        ticks(1);
        chk_all("rb_pulse_end", 3'b001, 3'b000, 3'b101);
        sel.Boton_R = 1'b0;
        sel.Boton_B = 1'b0;
        ticks(6);
        chk_all("rb_released", 3'b001, 3'b000, 3'b000);

        // Reset while blue is two cycles into the high filter, button kept held.
        sel.Boton_B = 1'b1;
        ticks(4);
        chk_all("b_filtering", 3'b001, 3'b000, 3'b000);
        resetM = 1'b1;
        ticks(1);
        chk_all("b_reset", 3'b000, 3'b000, 3'b000);
        resetM = 1'b0;
        ticks(5);
        chk_all("b_post_rst_before", 3'b000, 3'b000, 3'b000);
        ticks(1);
        chk_all("b_post_rst_accept", 3'b001, 3'b001, 3'b001);
        ticks(1);
        chk_all("b_post_rst_pulse_end", 3'b001, 3'b000, 3'b001);
        sel.Boton_B = 1'b0;
        ticks(6);
        chk_all("b_released", 3'b001, 3'b000, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
